// File: rtl/pc_jump_unit_pkg.sv
// pc_pkg: shared state encoding, address type and default parameters for the PC stage.
package pc_pkg;
   localparam int unsigned ADDR_W_DEF    = 16;
   localparam int unsigned RESET_VEC_DEF = 0;
   typedef logic [ADDR_W_DEF-1:0] addr_t;
   typedef enum logic [1:0] {BOOT, RUN, REDIRECT, HALT} pc_state_e;
endpackage

// File: rtl/jump_perf_counter.sv
// jump_perf_counter: enable-driven event counter that sticks at all-ones.
module jump_perf_counter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_d, cnt_q;
   always_comb cnt_d = (en_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   assign cnt_o = cnt_q;
endmodule

// File: rtl/pc_jump_unit.sv
// pc_jump_unit: program counter, fetch request and jump redirect stage.
// Optional jump statistics counters are built when PC_PERF_CNT_EN is defined.
module pc_jump_unit
   import pc_pkg::*;
#(
   parameter int unsigned       ADDR_W    = ADDR_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              halt_i,
   input  logic              instr_valid_i,
   input  logic              jump_i,
   input  logic              cond_ok_i,
   input  logic              link_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   output logic [ADDR_W-1:0] dec_pc_o,
   output logic              flush_o,
   output logic              jump_taken_o,
   output logic              link_we_o,
   output logic [ADDR_W-1:0] link_addr_o
`ifdef PC_PERF_CNT_EN
   ,
   output logic [31:0]       taken_cnt_o,
   output logic [31:0]       nottaken_cnt_o
`endif
);
   pc_state_e         state_d, state_q;
   logic [ADDR_W-1:0] pc_d, pc_q, dec_pc_d, dec_pc_q, redir_d, redir_q;
   logic              run, resolve, taken;

   assign run     = state_q == RUN;
   assign resolve = run & instr_valid_i & jump_i & ~stall_i & ~halt_i;
   assign taken   = resolve & cond_ok_i;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      dec_pc_d    = dec_pc_q;
      redir_d     = redir_q;
      imem_req_o  = 1'b0;
      imem_addr_o = pc_q;
      case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            imem_req_o  = taken | ~stall_i;
            imem_addr_o = taken ? target_i : pc_q;
            if (imem_req_o && imem_gnt_i) begin
               pc_d     = imem_addr_o + ADDR_W'(1);
               dec_pc_d = imem_addr_o;
            end else if (taken) begin
               redir_d = target_i;
               state_d = REDIRECT;
            end
            if (halt_i) state_d = HALT;
         end
         REDIRECT: begin
            imem_req_o  = 1'b1;
            imem_addr_o = redir_q;
            if (imem_gnt_i) begin
               pc_d     = redir_q + ADDR_W'(1);
               dec_pc_d = redir_q;
               state_d  = RUN;
            end
            if (halt_i) state_d = HALT;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q  <= BOOT;
         pc_q     <= RESET_VEC;
         dec_pc_q <= RESET_VEC;
         redir_q  <= RESET_VEC;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         dec_pc_q <= dec_pc_d;
         redir_q  <= redir_d;
      end

   assign dec_pc_o     = dec_pc_q;
   assign flush_o      = taken;
   assign jump_taken_o = taken;
   assign link_we_o    = taken & link_i;
   assign link_addr_o  = dec_pc_q + ADDR_W'(1);

`ifdef PC_PERF_CNT_EN
   jump_perf_counter #(.W(32)) u_taken_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (taken),
      .cnt_o (taken_cnt_o)
   );
   jump_perf_counter #(.W(32)) u_nottaken_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (resolve & ~cond_ok_i),
      .cnt_o (nottaken_cnt_o)
   );
`endif
endmodule
